// File: rtl/alu_out_capture_arb.sv
// Multi-channel ALU result collector: per-channel holding slots, round-robin
// merge into a timestamped FIFO, valid/ready output and drop accounting.
module alu_out_capture_arb #(
    parameter  int RESULT_WIDTH = 16,
    parameter  int NUM_CH       = 2,
    parameter  int DEPTH        = 8,
    parameter  int TS_WIDTH     = 16,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [NUM_CH-1:0]              ch_done,
    input  logic [NUM_CH*RESULT_WIDTH-1:0] ch_result,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RESULT_WIDTH-1:0]        out_result,
    output logic [CH_W-1:0]                out_ch,
    output logic [TS_WIDTH-1:0]            out_ts,
    output logic [CNT_W-1:0]               fifo_count,
    output logic [NUM_CH-1:0]              drop_sticky,
    output logic [15:0]                    drop_cnt,
    input  logic                           clear_drops
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TS_WIDTH-1:0]     r_ts;
    logic [NUM_CH-1:0]       r_slot_full;
    logic [RESULT_WIDTH-1:0] r_slot_res [NUM_CH];
    logic [TS_WIDTH-1:0]     r_slot_ts  [NUM_CH];
    logic [CH_W-1:0]         r_rr_ptr;

    logic [RESULT_WIDTH-1:0] r_mem_res [DEPTH];
    logic [CH_W-1:0]         r_mem_ch  [DEPTH];
    logic [TS_WIDTH-1:0]     r_mem_ts  [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic [NUM_CH-1:0]       r_drop_sticky;
    logic [15:0]             r_drop_cnt;

    logic                    w_fifo_full;
    logic                    w_grant_vld;
    logic [CH_W-1:0]         w_grant_idx;
    int unsigned             w_scan;
    logic [RESULT_WIDTH-1:0] w_grant_res;
    logic [TS_WIDTH-1:0]     w_grant_ts;
    logic                    w_pop;
    logic [NUM_CH-1:0]       w_drop;
    logic [3:0]              w_drop_num;
    logic [16:0]             w_drop_sum;
    logic [15:0]             w_drop_base;

    // Round-robin search starting at r_rr_ptr; fullness uses the registered
    // count only, so a same-cycle pop never makes room for a push.
    always_comb begin
        w_fifo_full = (r_count == CNT_W'(DEPTH));
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_scan = 32'(r_rr_ptr) + i;
            if (w_scan >= NUM_CH) begin
                w_scan = w_scan - NUM_CH;
            end
            if (!w_grant_vld && !w_fifo_full && r_slot_full[CH_W'(w_scan)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = CH_W'(w_scan);
            end
        end
    end

    assign w_grant_res = r_slot_res[w_grant_idx];
    assign w_grant_ts  = r_slot_ts[w_grant_idx];
    assign w_pop       = (r_count != '0) && out_ready;

    always_comb begin
        w_drop     = '0;
        w_drop_num = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_drop[k] = enable && ch_done[k] && r_slot_full[k] &&
                        !(w_grant_vld && (w_grant_idx == CH_W'(k)));
            w_drop_num = w_drop_num + 4'(w_drop[k]);
        end
        w_drop_base = clear_drops ? 16'h0000 : r_drop_cnt;
        w_drop_sum  = {1'b0, w_drop_base} + 17'(w_drop_num);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts <= '0;
        end else if (enable) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // A granted slot may reload in the same cycle; the load wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_full <= '0;
            r_rr_ptr    <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_slot_res[k] <= '0;
                r_slot_ts[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (enable && ch_done[k] && !w_drop[k]) begin
                    r_slot_full[k] <= 1'b1;
                    r_slot_res[k]  <= ch_result[k*RESULT_WIDTH +: RESULT_WIDTH];
                    r_slot_ts[k]   <= r_ts;
                end else if (w_grant_vld && (w_grant_idx == CH_W'(k))) begin
                    r_slot_full[k] <= 1'b0;
                end
            end
            if (w_grant_vld) begin
                if (32'(w_grant_idx) == NUM_CH - 1) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned d = 0; d < DEPTH; d++) begin
                r_mem_res[d] <= '0;
                r_mem_ch[d]  <= '0;
                r_mem_ts[d]  <= '0;
            end
        end else begin
            if (w_grant_vld) begin
                r_mem_res[r_wr_ptr] <= w_grant_res;
                r_mem_ch[r_wr_ptr]  <= w_grant_idx;
                r_mem_ts[r_wr_ptr]  <= w_grant_ts;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_grant_vld, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_sticky <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_drop_sticky <= (clear_drops ? '0 : r_drop_sticky) | w_drop;
            r_drop_cnt    <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_result  = r_mem_res[r_rd_ptr];
    assign out_ch      = r_mem_ch[r_rd_ptr];
    assign out_ts      = r_mem_ts[r_rd_ptr];
    assign fifo_count  = r_count;
    assign drop_sticky = r_drop_sticky;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_alu_out_capture_arb.sv
// Self-checking bench for alu_out_capture_arb: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_alu_out_capture_arb;

    localparam int RW = 16;
    localparam int NC = 2;
    localparam int DP = 8;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic [NC-1:0]   ch_done = '0;
    logic [NC*RW-1:0] ch_result = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [RW-1:0]   out_result;
    logic [0:0]      out_ch;
    logic [TW-1:0]   out_ts;
    logic [3:0]      fifo_count;
    logic [NC-1:0]   drop_sticky;
    logic [15:0]     drop_cnt;
    logic            clear_drops = 1'b0;

    alu_out_capture_arb #(
        .RESULT_WIDTH(RW),
        .NUM_CH      (NC),
        .DEPTH       (DP),
        .TS_WIDTH    (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ch_done    (ch_done),
        .ch_result  (ch_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ch     (out_ch),
        .out_ts     (out_ts),
        .fifo_count (fifo_count),
        .drop_sticky(drop_sticky),
        .drop_cnt   (drop_cnt),
        .clear_drops(clear_drops)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned res;
        int unsigned ch;
        int unsigned ts;
    } ent_t;

    ent_t        m_q[$];
    bit          m_full[NC];
    int unsigned m_res[NC];
    int unsigned m_sts[NC];
    int unsigned m_ts;
    int unsigned m_ptr;
    int unsigned m_sticky;
    int unsigned m_dcnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        for (int k = 0; k < NC; k++) begin
            m_full[k] = 0;
            m_res[k]  = 0;
            m_sts[k]  = 0;
        end
        m_ts = 0; m_ptr = 0; m_sticky = 0; m_dcnt = 0;
    endfunction

    // One clock of the behavioural rules applied to the inputs being driven.
    function automatic void model_clock(input bit en, input bit [NC-1:0] done,
                                        input bit [NC*RW-1:0] res, input bit rdy,
                                        input bit clr);
        int   grant = -1;
        int   ndrop = 0;
        bit   drop[NC];
        ent_t e;
        if (m_q.size() < DP) begin
            for (int i = 0; i < NC; i++) begin
                int k = (m_ptr + i) % NC;
                if (grant < 0 && m_full[k]) grant = k;
            end
        end
        for (int k = 0; k < NC; k++) begin
            drop[k] = en && done[k] && m_full[k] && (grant != k);
            if (drop[k]) ndrop++;
        end
        if (clr) begin
            m_dcnt = 0;
            m_sticky = 0;
        end
        m_dcnt = (m_dcnt + ndrop > 65535) ? 65535 : m_dcnt + ndrop;
        for (int k = 0; k < NC; k++) if (drop[k]) m_sticky |= (1 << k);
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (grant >= 0) begin
            e.res = m_res[grant]; e.ch = grant; e.ts = m_sts[grant];
            m_q.push_back(e);
            m_full[grant] = 0;
            m_ptr = (grant + 1) % NC;
        end
        for (int k = 0; k < NC; k++) begin
            if (en && done[k] && !drop[k]) begin
                m_full[k] = 1;
                m_res[k]  = (res >> (k * RW)) & 16'hFFFF;
                m_sts[k]  = m_ts;
            end
        end
        if (en) m_ts = (m_ts + 1) % (1 << TW);
    endfunction

    task automatic step(input bit en, input bit [NC-1:0] done, input bit [NC*RW-1:0] res,
                        input bit rdy, input bit clr);
        @(negedge clk);
        enable = en; ch_done = done; ch_result = res; out_ready = rdy; clear_drops = clr;
        model_clock(en, done, res, rdy, clr);
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_q.size() != 0);
        check("fifo_count", fifo_count, m_q.size());
        check("drop_sticky", drop_sticky, m_sticky);
        check("drop_cnt", drop_cnt, m_dcnt);
        if (m_q.size() != 0) begin
            check("out_result", out_result, m_q[0].res);
            check("out_ch", out_ch, m_q[0].ch);
            check("out_ts", out_ts, m_q[0].ts);
        end
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_result", out_result, 0);
        check("rst_ts", out_ts, 0);
        check("rst_dcnt", drop_cnt, 0);
        check("rst_sticky", drop_sticky, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single sample captured at ts=5, visible two edges later.
        for (int i = 0; i < 5; i++) step(1, 2'b00, '0, 1, 0);
        step(1, 2'b01, {16'h0, 16'h1234}, 1, 0);
        step(1, 2'b00, '0, 1, 0);
        check("ss_valid", out_valid, 1);
        check("ss_result", out_result, 16'h1234);
        check("ss_ch", out_ch, 0);
        check("ss_ts", out_ts, 5);
        step(1, 2'b00, '0, 1, 0);
        check("ss_drain", fifo_count, 0);
        for (int i = 0; i < 3; i++) step(1, 2'b00, '0, 1, 0);

        // Both channels pulsing back to back.
        for (int i = 0; i < 4; i++)
            step(1, 2'b11, {16'hB000 + 16'(i), 16'hA000 + 16'(i)}, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 2'b00, '0, 1, 0);

        // Back-pressure: 10 pulses on ch0, 2 cycles apart.
        step(1, 2'b00, '0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 2'b01, {16'h0, 16'hC000 + 16'(i)}, 0, 0);
            step(1, 2'b00, '0, 0, 0);
        end
        check("bp_count", fifo_count, 8);
        check("bp_dcnt", drop_cnt, 1);
        check("bp_sticky", drop_sticky, 2'b01);

        // Clear colliding with a ch1 drop.
        step(1, 2'b00, '0, 0, 1);
        step(1, 2'b10, {16'hD000, 16'h0}, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 2'b10, {16'hD001 + 16'(i), 16'h0}, 0, 0);
        check("pre_clr_dcnt", drop_cnt, 5);
        step(1, 2'b10, {16'hDEAD, 16'h0}, 0, 1);
        check("clr_dcnt", drop_cnt, 1);
        check("clr_sticky", drop_sticky, 2'b10);
        for (int i = 0; i < 14; i++) step(0, 2'b00, '0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) != 0, 2'($urandom), {16'($urandom), 16'($urandom)},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);

        // Drop counter saturation.
        for (int i = 0; i < 33000; i++)
            step(1, 2'b11, {16'($urandom), 16'($urandom)}, 0, 0);
        check("sat_dcnt", drop_cnt, 16'hFFFF);
        step(1, 2'b11, '0, 0, 0);
        check("sat_hold", drop_cnt, 16'hFFFF);

        step(0, 2'b00, '0, 1, 1);
        for (int i = 0; i < 14; i++) step(0, 2'b00, '0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 2'b01 << (i % 2), {16'hE000 + 16'(i), 16'hE000 + 16'(i)}, 0, 0);
            step(1, 2'b00, '0, 0, 0);
        end
        check("mid_count", fifo_count, 4);

        // Asynchronous reset mid-stream.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_count", fifo_count, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0; ch_done = '0; out_ready = 1'b0; clear_drops = 1'b0;
        step(1, 2'b00, '0, 1, 0);
        step(1, 2'b00, '0, 1, 0);
        step(1, 2'b01, {16'h0, 16'h5A5A}, 1, 0);
        step(1, 2'b00, '0, 1, 0);
        check("post_rst_ts", out_ts, 2);
        check("post_rst_res", out_result, 16'h5A5A);
        for (int i = 0; i < 3; i++) step(1, 2'b00, '0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
